ysyx_22050133_lsu: RTL and testbench

Memory-access stage sitting directly downstream of the execute stage and upstream of write-back. Takes the execute result (effective address or ALU value) plus store data, performs at most one data-memory transaction per instruction over a valid/ready request plus response-valid interface, and aligns and extends load data. Passes a valid/ready-handshaked result to write-back. Drives forward_data_mem back to the execute stage bypass mux.

---
 rtl/ysyx_22050133_lsu_pkg.sv | 36 +++
 rtl/ysyx_22050133_lsu_align.sv | 52 +++++
 rtl/ysyx_22050133_lsu.sv | 129 ++++++++++++
 tb/tb_ysyx_22050133_lsu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050133_lsu_pkg.sv
// Shared encodings for the load/store stage: memop, access size and FSM state.
package ysyx_22050133_lsu_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_RSVD  = 2'b11
    } memop_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

    function automatic logic [7:0] size_mask(size_e s);
        logic [7:0] m;
        unique case (s)
            SZ_B: m = 8'h01;
            SZ_H: m = 8'h03;
            SZ_W: m = 8'h0F;
            SZ_D: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22050133_lsu_align.sv
// Byte-lane steering for the LSU: store shift/strobe, load shift/extend,
// and natural-alignment check for an incoming access.
module ysyx_22050133_lsu_align
    import ysyx_22050133_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      chk_off,
    input  size_e           chk_size,
    output logic            misalign,
    input  logic [2:0]      off,
    input  size_e           size,
    input  logic            is_unsigned,
    input  logic            is_store,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] ldata
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] sh;

    assign shamt = SW'({off, 3'b000});
    assign wdata = st_data << shamt;
    assign wstrb = is_store ? (size_mask(size) << off) : 8'h00;
    assign sh    = rdata >> shamt;

    always_comb begin
        misalign = 1'b0;
        unique case (chk_size)
            SZ_B: misalign = 1'b0;
            SZ_H: misalign = chk_off[0];
            SZ_W: misalign = |chk_off[1:0];
            SZ_D: misalign = |chk_off;
        endcase
    end

    always_comb begin
        ldata = sh;
        unique case (size)
            SZ_B: ldata = {{(XLEN-8){~is_unsigned & sh[7]}}, sh[7:0]};
            SZ_H: ldata = {{(XLEN-16){~is_unsigned & sh[15]}}, sh[15:0]};
            SZ_W: ldata = {{(XLEN-32){~is_unsigned & sh[31]}}, sh[31:0]};
            SZ_D: ldata = sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22050133_lsu.sv
// Memory-access stage: one data-memory transaction per instruction,
// valid/ready towards write-back, bypass value back to execute.
module ysyx_22050133_lsu
    import ysyx_22050133_lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_memop,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_rf_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [4:0]        out_rd,
    output logic              out_rf_wen,
    output logic              out_misalign,
    output logic [XLEN-1:0]   forward_data_mem,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wen,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    lsu_state_e state, state_nxt, tgt;
    memop_e     op_in;
    logic       in_load, in_store, in_mem, chk_mis, in_mis, accept;

    logic            load_q, store_q, uns_q, wen_q, mis_q;
    size_e           size_q;
    logic [XLEN-1:0] result_q, wdata_q, data_q, ldata;
    logic [4:0]      rd_q;

    assign op_in    = memop_e'(in_memop);
    assign in_load  = (op_in == MEM_LOAD);
    assign in_store = (op_in == MEM_STORE);
    assign in_mem   = in_load | in_store;
    assign in_mis   = in_mem & chk_mis;
    assign accept   = in_valid & in_ready;
    assign tgt      = (in_mem && !in_mis) ? LSU_REQ : LSU_DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LSU_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            LSU_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = tgt;
            end
            LSU_REQ:  if (dmem_req_ready) state_nxt = LSU_WAIT;
            LSU_WAIT: if (dmem_resp_valid) state_nxt = LSU_DONE;
            LSU_DONE: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = in_valid ? tgt : LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            uns_q    <= 1'b0;
            wen_q    <= 1'b0;
            mis_q    <= 1'b0;
            size_q   <= SZ_B;
            result_q <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            load_q   <= in_load & ~in_mis;
            store_q  <= in_store & ~in_mis;
            uns_q    <= in_unsigned;
            wen_q    <= in_rf_wen & (in_rd != 5'd0) & ~in_mis;
            mis_q    <= in_mis;
            size_q   <= size_e'(in_size);
            result_q <= in_result;
            wdata_q  <= in_wdata;
            data_q   <= in_mis ? '0 : in_result;
            rd_q     <= in_rd;
        end else if (state == LSU_WAIT && dmem_resp_valid && load_q) begin
            data_q   <= ldata;
        end
    end

    ysyx_22050133_lsu_align #(.XLEN(XLEN)) u_align (
        .chk_off     (in_result[2:0]),
        .chk_size    (size_e'(in_size)),
        .misalign    (chk_mis),
        .off         (result_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .is_store    (store_q),
        .st_data     (wdata_q),
        .rdata       (dmem_rdata),
        .wdata       (dmem_wdata),
        .wstrb       (dmem_wstrb),
        .ldata       (ldata)
    );

    assign out_valid        = (state == LSU_DONE);
    assign out_data         = data_q;
    assign out_rd           = rd_q;
    assign out_rf_wen       = wen_q;
    assign out_misalign     = mis_q;
    assign forward_data_mem = result_q;
    assign dmem_req_valid   = (state == LSU_REQ);
    assign dmem_addr        = result_q[ADDR_W-1:0];
    assign dmem_wen         = store_q;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed scoreboard bench for the LSU stage.
module tb_ysyx_22050133_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_memop, in_size;
    logic        in_unsigned;
    logic [63:0] in_result, in_wdata;
    logic [4:0]  in_rd;
    logic        in_rf_wen;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_rf_wen, out_misalign;
    logic [63:0] forward_data_mem;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [63:0] dmem_rdata;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050133_lsu #(.XLEN(64), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_memop         (in_memop),
        .in_size          (in_size),
        .in_unsigned      (in_unsigned),
        .in_result        (in_result),
        .in_wdata         (in_wdata),
        .in_rd            (in_rd),
        .in_rf_wen        (in_rf_wen),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_rd           (out_rd),
        .out_rf_wen       (out_rf_wen),
        .out_misalign     (out_misalign),
        .forward_data_mem (forward_data_mem),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_addr        (dmem_addr),
        .dmem_wen         (dmem_wen),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_rdata       (dmem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [4:0] rd,
                        input logic wen, input logic mis);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.wen  = wen & (rd != 5'd0) & ~mis;
        e.mis  = mis;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, out_data, e.data);
            check({tag, "_rd"}, 64'(out_rd), 64'(e.rd));
            check({tag, "_wen"}, 64'(out_rf_wen), 64'(e.wen));
            check({tag, "_mis"}, 64'(out_misalign), 64'(e.mis));
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] sz,
                         input logic uns, input logic [63:0] res,
                         input logic [63:0] wd, input logic [4:0] rd,
                         input logic wen);
        in_valid    = 1'b1;
        in_memop    = op;
        in_size     = sz;
        in_unsigned = uns;
        in_result   = res;
        in_wdata    = wd;
        in_rd       = rd;
        in_rf_wen   = wen;
    endtask

    // Zero-wait memory transaction starting from IDLE at a negedge.
    task automatic mem_op(input string tag, input logic [1:0] op,
                          input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] rdt, input logic [4:0] rd,
                          input logic [63:0] expd, input logic [7:0] estrb,
                          input logic [63:0] ewd);
        logic is_st;
        is_st = (op == 2'b10);
        dmem_req_ready = 1'b1;
        drive(op, sz, uns, addr, wd, rd, ~is_st);
        push(expd, rd, ~is_st, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_req"}, 64'(dmem_req_valid), 64'd1);
        check({tag, "_addr"}, 64'(dmem_addr), 64'(addr[31:0]));
        check({tag, "_wen"}, 64'(dmem_wen), 64'(is_st));
        check({tag, "_strb"}, 64'(dmem_wstrb), 64'(estrb));
        if (is_st) check({tag, "_wdata"}, dmem_wdata, ewd);
        @(negedge clk);
        check({tag, "_wait_req"}, 64'(dmem_req_valid), 64'd0);
        check({tag, "_wait_ov"}, 64'(out_valid), 64'd0);
        dmem_resp_valid = 1'b1;
        dmem_rdata      = rdt;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        check({tag, "_lat3"}, 64'(out_valid), 64'd1);
        pop_cmp(tag);
        @(negedge clk);
        check({tag, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(2'b00, 2'b00, 1'b0, '0, '0, '0, 1'b0);
        in_valid        = 1'b0;
        out_ready       = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_rdata      = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req", 64'(dmem_req_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_fwd", forward_data_mem, 64'd0);
        check("rst_strb", 64'(dmem_wstrb), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // ALU passthrough, one-cycle latency
        drive(2'b00, 2'b00, 1'b0, 64'h1234, '0, 5'd5, 1'b1);
        push(64'h1234, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("alu_valid", 64'(out_valid), 64'd1);
        check("alu_req", 64'(dmem_req_valid), 64'd0);
        check("alu_fwd", forward_data_mem, 64'h1234);
        pop_cmp("alu");
        @(negedge clk);

        mem_op("lb", 2'b01, 2'b00, 1'b0, 64'h80000003, '0,
               64'h00000000_80FF0000, 5'd7, 64'hFFFFFFFF_FFFFFF80,
               8'h00, '0);
        mem_op("lhu", 2'b01, 2'b01, 1'b1, 64'h80000002, '0,
               64'h00000000_F00D0000, 5'd8, 64'h0000_0000_0000_F00D,
               8'h00, '0);
        mem_op("lw", 2'b01, 2'b10, 1'b0, 64'h80000004, '0,
               64'h87654321_00000000, 5'd9, 64'hFFFFFFFF_87654321,
               8'h00, '0);
        mem_op("ld", 2'b01, 2'b11, 1'b1, 64'h80000008, '0,
               64'h01234567_89ABCDEF, 5'd10, 64'h01234567_89ABCDEF,
               8'h00, '0);
        mem_op("sw", 2'b10, 2'b10, 1'b0, 64'h80000004,
               64'h1122_3344_DEAD_BEEF, '0, 5'd11, 64'h80000004,
               8'hF0, 64'hDEAD_BEEF_0000_0000);

        // Half store with stalled request acceptance
        dmem_req_ready = 1'b0;
        drive(2'b10, 2'b01, 1'b0, 64'h80000006, 64'hABCD, 5'd0, 1'b1);
        push(64'h80000006, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sh_req%0d", i), 64'(dmem_req_valid), 64'd1);
            check($sformatf("sh_strb%0d", i), 64'(dmem_wstrb), 64'hC0);
            check($sformatf("sh_wd%0d", i), dmem_wdata,
                  64'hABCD_0000_0000_0000);
            check($sformatf("sh_wen%0d", i), 64'(dmem_wen), 64'd1);
            check($sformatf("sh_addr%0d", i), 64'(dmem_addr),
                  64'h80000006);
            if (i < 3) @(negedge clk);
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        check("sh_wait_req", 64'(dmem_req_valid), 64'd0);
        dmem_resp_valid = 1'b1;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        check("sh_done", 64'(out_valid), 64'd1);
        pop_cmp("sh");
        @(negedge clk);

        // Misaligned word load: no request
        drive(2'b01, 2'b10, 1'b0, 64'h80000002, '0, 5'd3, 1'b1);
        push(64'd0, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("mis_valid", 64'(out_valid), 64'd1);
        check("mis_req", 64'(dmem_req_valid), 64'd0);
        pop_cmp("mis");
        @(negedge clk);
        check("mis_req2", 64'(dmem_req_valid), 64'd0);

        // Back-pressure, then back-to-back accept
        out_ready = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 64'hAAAA, '0, 5'd1, 1'b1);
        push(64'hAAAA, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0, 64'hBBBB, '0, 5'd2, 1'b1);
        pop_cmp("bp_a");
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_ov%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_data%0d", i), out_data, 64'hAAAA);
            check($sformatf("bp_rd%0d", i), 64'(out_rd), 64'd1);
            check($sformatf("bp_inr%0d", i), 64'(in_ready), 64'd0);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        push(64'hBBBB, 5'd2, 1'b1, 1'b0);
        #1;
        check("b2b_inr", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_ov", 64'(out_valid), 64'd1);
        pop_cmp("b2b");
        @(negedge clk);
        check("b2b_idle", 64'(out_valid), 64'd0);

        // Reset while waiting for a load response
        dmem_req_ready = 1'b1;
        drive(2'b01, 2'b11, 1'b0, 64'h80000010, '0, 5'd4, 1'b1);
        push(64'h5555, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rw_inr_wait", 64'(in_ready), 64'd0);
        rst = 1'b0;
        sb.delete();
        #1;
        check("rw_async_inr", 64'(in_ready), 64'd1);
        check("rw_async_ov", 64'(out_valid), 64'd0);
        check("rw_async_fwd", forward_data_mem, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'h5555;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        check("rw_ov", 64'(out_valid), 64'd0);
        check("rw_inr", 64'(in_ready), 64'd1);
        check("rw_req", 64'(dmem_req_valid), 64'd0);
        check("rw_data", out_data, 64'd0);
        @(negedge clk);
        check("rw_ov2", 64'(out_valid), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
